ex_stage: RTL
=============

// Module: ex_stage
// PURPOSE
//  Execute stage, the consumer of the decoder's {alu_op, alu_sel, reg0, reg1, waddr, wreg} bundle.
//  Holds the ID/EX pipeline register, computes logic/shift/move results, and owns the HI/LO registers.
//  Runs MULT/MULTU as a 32-cycle iterative shift-add and requests an upstream stall while busy.
//  Drives ex_o_wreg/ex_o_waddr/ex_o_wdata, which feed the decoder's forwarding path and the MEM stage.
// PARAMETERS
//  W           32      datapath width; only 32 is supported
//  HILO_RST    32'h0   reset value of the HI and LO registers
// PORTS
//  clk           in   1   clock, rising edge
//  rst_          in   1   asynchronous active-low reset
//  ex_i_vld      in   1   decoded bundle valid this cycle
//  ex_i_alu_op   in   8   `EXE_OP_* code; adds `EXE_OP_MULT and `EXE_OP_MULTU to the defines
//  ex_i_alu_sel  in   3   `EXE_RES_* result group
//  ex_i_reg0     in   32  operand 0 (rs, shamt or imm)
//  ex_i_reg1     in   32  operand 1 (rt or imm)
//  ex_i_waddr    in   5   GPR destination
//  ex_i_wreg     in   1   GPR write enable
//  stall_req     out  1   upstream holds its outputs while this is high
//  ex_o_wreg     out  1   GPR write enable of the current result
//  ex_o_waddr    out  5   GPR destination of the current result
//  ex_o_wdata    out  32  GPR write data
// BEHAVIOUR
//  - ID/EX register: loaded on each clk edge when state==IDLE. Load value is the ex_i_* bundle if ex_i_vld, else all-zero (bubble).
//  - ex_o_* are combinational from the ID/EX register. Latency is 1 clk from input to ex_o_*.
//  - Reset (async): ID/EX register=0, state=IDLE, counter=0, HI=LO=HILO_RST.
//    Outputs under reset: stall_req=0, ex_o_wreg=0, ex_o_waddr=0, ex_o_wdata=0.
//  - ex_o_wdata by alu_sel:
//    - LOGIC: AND/OR/XOR/NOR of reg0 and reg1.
//    - SHIFT: reg1 shifted by reg0[4:0]; SLL and SRL zero-fill, SRA sign-fills.
//    - MOVE: MOVZ/MOVN give reg0; MFHI gives HI; MFLO gives LO.
//    - NOP or any unknown sel: 0.
//  - ex_o_wreg = registered wreg; it is forced to 0 while state==MUL.
//  - MTHI/MTLO: HI (or LO) <= reg0 at the end of the EX cycle. An MFHI/MFLO in the next cycle sees the new value; no forwarding is needed.
//  - FSM IDLE->MUL: taken when the ID/EX register holds MULT/MULTU.
//    - Latch |a|,|b| (MULT, signed) or a,b (MULTU) into a 64-bit accumulator and a shifter.
//    - Record the result sign = a[31]^b[31], for MULT only.
//    - Clear the counter.
//  - MUL state:
//    - stall_req=1, combinational on state.
//    - Each edge adds the shifted multiplicand when the current multiplier bit is 1, then increments the counter.
//    - On the edge where the counter is 31: write {HI,LO} = product, negated if the sign bit is set; go to IDLE.
//    - stall_req is high for exactly 32 cycles per multiply.
//  - While stalled the ID/EX register and ex_i_* are ignored; upstream keeps the next bundle stable.
//  - A multiply produces no GPR write (ex_o_wreg=0 during the MUL entry cycle too).
//  - Reset asserted mid-multiply aborts it: stall_req drops asynchronously, HI/LO take HILO_RST, and no partial product is written.
//  - Signed corner: 0x80000000 has magnitude 2^31, which fits an unsigned 32-bit value; the result must still be correct.
// TESTING
//  1. OR reg0=0x00001100, reg1=0x00000020, waddr=5, wreg=1 -> next cycle ex_o_wdata=0x00001120, ex_o_waddr=5, ex_o_wreg=1.
//  2. SRA reg0=4, reg1=0x80000000 -> 0xF8000000; SRL with the same operands -> 0x08000000.
//  3. MULT reg0=0xFFFFFFFD(-3), reg1=5 -> stall_req high for 32 cycles, ex_o_wreg=0 throughout.
//     Then HI=0xFFFFFFFF, LO=0xFFFFFFF1; the following MFLO gives 0xFFFFFFF1.
//  4. MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
//     MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
//  5. MTHI reg0=0x00001234, then MFHI on the next cycle -> ex_o_wdata=0x00001234.
//     ex_i_vld=0 -> bubble with ex_o_wreg=0 and ex_o_wdata=0.
//  6. rst_ low on the 10th cycle of a MULT -> stall_req=0 immediately and HI=LO=0.
//     After release, the next OR executes normally.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: ID/EX pipeline register, logic/shift/move results, HI/LO registers,
// and a 32-cycle iterative MULT/MULTU that stalls the front end while busy.
module ex_stage #(
  parameter int unsigned W        = 32,
  parameter logic [31:0] HILO_RST = 32'h0
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         ex_i_vld,
  input  logic [7:0]   ex_i_alu_op,
  input  logic [2:0]   ex_i_alu_sel,
  input  logic [W-1:0] ex_i_reg0,
  input  logic [W-1:0] ex_i_reg1,
  input  logic [4:0]   ex_i_waddr,
  input  logic         ex_i_wreg,
  output logic         stall_req,
  output logic         ex_o_wreg,
  output logic [4:0]   ex_o_waddr,
  output logic [W-1:0] ex_o_wdata
);

  localparam logic [7:0] OpNop   = 8'b0000_0000;
  localparam logic [7:0] OpAnd   = 8'b0010_0100;
  localparam logic [7:0] OpOr    = 8'b0010_0101;
  localparam logic [7:0] OpXor   = 8'b0010_0110;
  localparam logic [7:0] OpNor   = 8'b0010_0111;
  localparam logic [7:0] OpSll   = 8'b0111_1100;
  localparam logic [7:0] OpSrl   = 8'b0000_0010;
  localparam logic [7:0] OpSra   = 8'b0000_0011;
  localparam logic [7:0] OpMovz  = 8'b0000_1010;
  localparam logic [7:0] OpMovn  = 8'b0000_1011;
  localparam logic [7:0] OpMfhi  = 8'b0001_0000;
  localparam logic [7:0] OpMthi  = 8'b0001_0001;
  localparam logic [7:0] OpMflo  = 8'b0001_0010;
  localparam logic [7:0] OpMtlo  = 8'b0001_0011;
  localparam logic [7:0] OpMult  = 8'b0001_1000;
  localparam logic [7:0] OpMultu = 8'b0001_1001;

  localparam logic [2:0] ResNop   = 3'b000;
  localparam logic [2:0] ResLogic = 3'b001;
  localparam logic [2:0] ResShift = 3'b010;
  localparam logic [2:0] ResMove  = 3'b011;

  typedef enum logic {StIdle, StMul} state_t;

  state_t r_state, w_state_nxt;

  logic [7:0]     r_op;
  logic [2:0]     r_sel;
  logic [W-1:0]   r_reg0, r_reg1;
  logic [4:0]     r_waddr;
  logic           r_wreg;

  logic [4:0]     r_cnt;
  logic [2*W-1:0] r_acc, r_mcand;
  logic [W-1:0]   r_mplr;
  logic           r_neg;
  logic [W-1:0]   r_hi, r_lo;

  logic           w_is_mul, w_idle, w_last;
  logic           w_a_neg, w_b_neg;
  logic [W-1:0]   w_a_mag, w_b_mag;
  logic [2*W-1:0] w_acc_nxt, w_prod;
  logic [W-1:0]   w_result;

  assign w_idle   = (r_state == StIdle);
  assign w_is_mul = (r_op == OpMult) || (r_op == OpMultu);
  assign w_last   = (r_state == StMul) && (r_cnt == 5'd31);

  // ID/EX register; frozen while the multiplier owns the stage.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_op    <= '0;
      r_sel   <= '0;
      r_reg0  <= '0;
      r_reg1  <= '0;
      r_waddr <= '0;
      r_wreg  <= 1'b0;
    end else if (w_idle) begin
      if (ex_i_vld) begin
        r_op    <= ex_i_alu_op;
        r_sel   <= ex_i_alu_sel;
        r_reg0  <= ex_i_reg0;
        r_reg1  <= ex_i_reg1;
        r_waddr <= ex_i_waddr;
        r_wreg  <= ex_i_wreg;
      end else begin
        r_op    <= OpNop;
        r_sel   <= ResNop;
        r_reg0  <= '0;
        r_reg1  <= '0;
        r_waddr <= '0;
        r_wreg  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: if (w_is_mul) w_state_nxt = StMul;
      StMul:  if (r_cnt == 5'd31) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Signed multiply runs on magnitudes; 0x80000000 negates to itself, which is 2^31 unsigned.
  assign w_a_neg   = (r_op == OpMult) && r_reg0[W-1];
  assign w_b_neg   = (r_op == OpMult) && r_reg1[W-1];
  assign w_a_mag   = w_a_neg ? (~r_reg0 + 1'b1) : r_reg0;
  assign w_b_mag   = w_b_neg ? (~r_reg1 + 1'b1) : r_reg1;
  assign w_acc_nxt = r_acc + (r_mplr[0] ? r_mcand : '0);
  assign w_prod    = r_neg ? (~w_acc_nxt + 1'b1) : w_acc_nxt;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_neg   <= 1'b0;
    end else if (w_idle) begin
      if (w_is_mul) begin
        r_cnt   <= '0;
        r_acc   <= '0;
        r_mcand <= {{W{1'b0}}, w_a_mag};
        r_mplr  <= w_b_mag;
        r_neg   <= w_a_neg ^ w_b_neg;
      end
    end else begin
      r_cnt   <= r_cnt + 5'd1;
      r_acc   <= w_acc_nxt;
      r_mcand <= {r_mcand[2*W-2:0], 1'b0};
      r_mplr  <= {1'b0, r_mplr[W-1:1]};
    end
  end

  // HI/LO: product on the final multiply edge, MTHI/MTLO only when the stage is live.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_hi <= HILO_RST;
      r_lo <= HILO_RST;
    end else if (w_last) begin
      r_hi <= w_prod[2*W-1:W];
      r_lo <= w_prod[W-1:0];
    end else if (w_idle) begin
      if (r_op == OpMthi) r_hi <= r_reg0;
      if (r_op == OpMtlo) r_lo <= r_reg0;
    end
  end

  always_comb begin
    w_result = '0;
    case (r_sel)
      ResLogic: begin
        case (r_op)
          OpAnd:   w_result = r_reg0 & r_reg1;
          OpOr:    w_result = r_reg0 | r_reg1;
          OpXor:   w_result = r_reg0 ^ r_reg1;
          OpNor:   w_result = ~(r_reg0 | r_reg1);
          default: w_result = '0;
        endcase
      end
      ResShift: begin
        case (r_op)
          OpSll:   w_result = r_reg1 << r_reg0[4:0];
          OpSrl:   w_result = r_reg1 >> r_reg0[4:0];
          OpSra:   w_result = $signed(r_reg1) >>> r_reg0[4:0];
          default: w_result = '0;
        endcase
      end
      ResMove: begin
        case (r_op)
          OpMovz, OpMovn: w_result = r_reg0;
          OpMfhi:         w_result = r_hi;
          OpMflo:         w_result = r_lo;
          default:        w_result = '0;
        endcase
      end
      default: w_result = '0;
    endcase
  end

  assign stall_req  = (r_state == StMul);
  assign ex_o_wreg  = r_wreg && w_idle && !w_is_mul;
  assign ex_o_waddr = r_waddr;
  assign ex_o_wdata = w_result;

endmodule
